// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 256-bit data memory port between dcache (m0) and icache (m1).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise master 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, RELEASE} state_t;

    state_t state_q;
    logic   mem_enable_q;
    logic   pick0;
    logic   g0;
    logic   g1;

`ifdef MEM_ARB_RR_EN
    logic rr_last_q;
    // rr_last_q=1 means m1 was served last, so m0 wins a tie
    assign pick0 = m0_enable_i & (~m1_enable_i | rr_last_q);
`else
    assign pick0 = m0_enable_i;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_last_q    <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: if (m0_enable_i | m1_enable_i) begin
                    state_q      <= pick0 ? GRANT0 : GRANT1;
                    mem_enable_q <= 1'b1;
`ifdef MEM_ARB_RR_EN
                    rr_last_q    <= ~pick0;
`endif
                end
                GRANT0, GRANT1: if (mem_ack_i) begin
                    state_q      <= RELEASE;
                    mem_enable_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign g0           = state_q == GRANT0;
    assign g1           = state_q == GRANT1;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = g0 ? m0_write_i : g1 ? m1_write_i : 1'b0;
    assign mem_addr_o   = g0 ? m0_addr_i  : g1 ? m1_addr_i  : '0;
    assign mem_data_o   = g0 ? m0_data_i  : g1 ? m1_data_i  : '0;
    assign m0_ack_o     = mem_ack_i & g0;
    assign m1_ack_o     = mem_ack_i & g1;
    assign m0_data_o    = mem_data_i;
    assign m1_data_o    = mem_data_i;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter; a task-driven memory model acks each grant.
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         m0_enable_i = 1'b0, m0_write_i = 1'b0;
    logic [31:0]  m0_addr_i = '0;
    logic [255:0] m0_data_i = '0, m0_data_o;
    logic         m0_ack_o;
    logic         m1_enable_i = 1'b0, m1_write_i = 1'b0;
    logic [31:0]  m1_addr_i = '0;
    logic [255:0] m1_data_i = '0, m1_data_o;
    logic         m1_ack_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    typedef struct {
        bit           m;
        logic         w;
        logic [31:0]  a;
        logic [255:0] d;
        logic [255:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_12 = {16{16'h1234}};

    mem_arbiter #(.ADDR_W(32), .DATA_W(256)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    // Memory model: waits for the grant, holds it dly cycles, acks once, and scores the transaction.
    // Returns lat = negedges counted until mem_enable_o was seen high.
    task automatic serve(input string nm, input int dly, output int lat);
        exp_t e;
        bit   stable;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_enable_o && lat < 20);
        vectors++;
        if (mem_enable_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s grant_timeout mem_enable_o=%b required 1", nm, mem_enable_o);
            return;
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s unexpected_grant addr=%h", nm, mem_addr_o);
            return;
        end
        e = exp_q.pop_front();
        if ({mem_write_o, mem_addr_o, mem_data_o} !== {e.w, e.a, e.d}) begin
            miscompares++;
            $display("FAIL %s mux w=%b a=%h d=%h required w=%b a=%h d=%h", nm,
                     mem_write_o, mem_addr_o, mem_data_o[31:0], e.w, e.a, e.d[31:0]);
        end
        stable = 1'b1;
        repeat (dly) begin
            @(negedge clk);
            if (mem_enable_o !== 1'b1 || mem_addr_o !== e.a || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0)
                stable = 1'b0;
        end
        vectors++;
        if (!stable) begin
            miscompares++;
            $display("FAIL %s grant_hold unstable during wait, required en=1 addr=%h no ack", nm, e.a);
        end
        @(posedge clk);
        #1;
        mem_ack_i  = 1'b1;
        mem_data_i = e.rd;
        @(negedge clk);
        vectors++;
        if ({m1_ack_o, m0_ack_o} !== (e.m ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL %s ack_route acks=%b%b required %b", nm, m1_ack_o, m0_ack_o, e.m ? 2'b10 : 2'b01);
        end
        vectors++;
        if ((e.m ? m1_data_o : m0_data_o) !== e.rd || m0_data_o !== m1_data_o) begin
            miscompares++;
            $display("FAIL %s rdata m0=%h m1=%h required %h", nm, m0_data_o[31:0], m1_data_o[31:0], e.rd[31:0]);
        end
        @(posedge clk);
        #1;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        vectors++;
        if ({mem_enable_o, m1_ack_o, m0_ack_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s release en/acks=%b required 000", nm, {mem_enable_o, m1_ack_o, m0_ack_o});
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        m0_enable_i = 1'b0;
        m1_enable_i = 1'b0;
        mem_ack_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        int lat;
        m0_enable_i = 1'b1;
        m0_write_i = 1'b0;
        m0_addr_i = 32'h40;
        m0_data_i = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({mem_enable_o, m0_ack_o, m1_ack_o, mem_write_o} !== 4'b0 || mem_addr_o !== '0 || mem_data_o !== '0) begin
            miscompares++;
            $display("FAIL reset_state en=%b ack0=%b addr=%h required all zero", mem_enable_o, m0_ack_o, mem_addr_o);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        exp_q.push_back('{m: 1'b0, w: 1'b0, a: 32'h40, d: '0, rd: {8{32'hCAFE0001}}});
        serve("reset_release", 1, lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL reset_latency lat=%0d required 2", lat);
        end
        m0_enable_i = 1'b0;
    endtask

    task automatic test_single_read();
        int lat;
        m1_enable_i = 1'b1;
        m1_write_i = 1'b0;
        m1_addr_i = 32'h400;
        m1_data_i = {8{32'h0BADF00D}};
        exp_q.push_back('{m: 1'b1, w: 1'b0, a: 32'h400, d: {8{32'h0BADF00D}}, rd: PAT_A5});
        serve("single_read", 10, lat);
        m1_enable_i = 1'b0;
    endtask

    task automatic test_write();
        int lat;
        m0_enable_i = 1'b1;
        m0_write_i = 1'b1;
        m0_addr_i = 32'h20;
        m0_data_i = PAT_12;
        exp_q.push_back('{m: 1'b0, w: 1'b1, a: 32'h20, d: PAT_12, rd: '0});
        serve("write", 3, lat);
        m0_enable_i = 1'b0;
        m0_write_i = 1'b0;
    endtask

    task automatic test_contention();
        int lat;
        do_reset();
        m0_enable_i = 1'b1;
        m0_addr_i = 32'h1000;
        m0_data_i = {8{32'h11111111}};
        m1_enable_i = 1'b1;
        m1_addr_i = 32'h2000;
        m1_data_i = {8{32'h22222222}};
        exp_q.push_back('{m: 1'b0, w: 1'b0, a: 32'h1000, d: {8{32'h11111111}}, rd: {8{32'hAAAA0000}}});
        exp_q.push_back('{m: 1'b1, w: 1'b0, a: 32'h2000, d: {8{32'h22222222}}, rd: {8{32'hBBBB0000}}});
        serve("contend_first", 4, lat);
        m0_enable_i = 1'b0;
        serve("contend_second", 2, lat);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL contend_gap lat=%0d required 3", lat);
        end
        m1_enable_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  lat;
        bit  order[4];
`ifdef MEM_ARB_RR_EN
        order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        m0_enable_i = 1'b1;
        m0_addr_i = 32'h200;
        m0_data_i = {8{32'h33333333}};
        m1_enable_i = 1'b1;
        m1_addr_i = 32'h300;
        m1_data_i = {8{32'h44444444}};
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{m: order[i], w: 1'b0, a: order[i] ? 32'h300 : 32'h200,
                              d: order[i] ? {8{32'h44444444}} : {8{32'h33333333}}, rd: {8{i + 32'h50}}});
        for (int i = 0; i < 4; i++) begin
            serve("back_to_back", 1, lat);
            if (i > 0) begin
                vectors++;
                if (lat !== 3) begin
                    miscompares++;
                    $display("FAIL b2b_gap txn=%0d lat=%0d required 3", i, lat);
                end
            end
        end
        m0_enable_i = 1'b0;
        m1_enable_i = 1'b0;
    endtask

    task automatic test_stray_ack();
        int lat;
        repeat (3) @(posedge clk);
        #1;
        mem_ack_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_enable_o, m1_ack_o, m0_ack_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL stray_ack en/acks=%b required 000", {mem_enable_o, m1_ack_o, m0_ack_o});
        end
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
        m0_enable_i = 1'b1;
        m0_write_i = 1'b0;
        m0_addr_i = 32'h80;
        exp_q.push_back('{m: 1'b0, w: 1'b0, a: 32'h80, d: m0_data_i, rd: {8{32'h77777777}}});
        serve("after_stray", 1, lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL stray_idle lat=%0d required 2", lat);
        end
        m0_enable_i = 1'b0;
    endtask

    task automatic test_writeback_refill();
        int lat;
        m0_enable_i = 1'b1;
        m0_write_i = 1'b1;
        m0_addr_i = 32'h100;
        m0_data_i = {8{32'hDEADBEEF}};
        exp_q.push_back('{m: 1'b0, w: 1'b1, a: 32'h100, d: {8{32'hDEADBEEF}}, rd: '0});
        exp_q.push_back('{m: 1'b0, w: 1'b0, a: 32'h140, d: {8{32'hDEADBEEF}}, rd: {8{32'h0F0F0F0F}}});
        serve("writeback", 2, lat);
        m0_write_i = 1'b0;
        m0_addr_i = 32'h140;
        serve("refill", 2, lat);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL refill_gap lat=%0d required 3", lat);
        end
        m0_enable_i = 1'b0;
    endtask

    task automatic test_enable_drop();
        int lat;
        m1_enable_i = 1'b1;
        m1_write_i = 1'b1;
        m1_addr_i = 32'h600;
        m1_data_i = {8{32'h66666666}};
        exp_q.push_back('{m: 1'b1, w: 1'b1, a: 32'h600, d: {8{32'h66666666}}, rd: '0});
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        m1_enable_i = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h600) begin
            miscompares++;
            $display("FAIL drop_hold en=%b addr=%h required 1 00000600", mem_enable_o, mem_addr_o);
        end
        serve("drop_ack", 1, lat);
    endtask

    task automatic test_mid_reset();
        m1_enable_i = 1'b1;
        m1_write_i = 1'b0;
        m1_addr_i = 32'h700;
        repeat (3) @(negedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        vectors++;
        if ({mem_enable_o, m1_ack_o, m0_ack_o} !== 3'b000 || mem_addr_o !== '0) begin
            miscompares++;
            $display("FAIL mid_reset en=%b addr=%h required 0 00000000", mem_enable_o, mem_addr_o);
        end
        m1_enable_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_back_to_back();
        test_stray_ack();
        test_writeback_refill();
        test_enable_drop();
        test_mid_reset();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover entries=%0d required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
